apb_timer_slave: RTL and testbench
==================================

Name: apb_timer_slave

Overview:
APB responder and 8-bit timer core. It is the completer end of the CPU bus-functional model's APB transactions. It decodes APB reads and writes to four byte registers (TDR, TCR, TSR, TCNT). It runs an up/down counter clocked by a PCLK/2, /4, /8 or /16 prescaler and flags overflow and underflow. It sits under timer_testbench as the DUT driven by the CPU and SYSTEM models.

Parameters:
WAIT_CYCLES, 0, wait states inserted in each access phase before pready asserts (0..15)
ADDR_W, 8, paddr width

Ports:
pclk  in  1  APB clock; the only clock
presetn  in  1  asynchronous active-low reset
psel  in  1  APB select
penable  in  1  APB access phase
pwrite  in  1  1 = write, 0 = read
paddr  in  ADDR_W  register address
pwdata  in  8  write data
prdata  out  8  read data; valid only while pready=1
pready  out  1  transfer complete
pslverr  out  1  error response; valid only while pready=1

Behaviour:
- Reset: presetn=0 asynchronously clears TDR, TCR, TSR, TCNT, the prescaler and the wait counter. prdata=0x00, pready=0, pslverr=0. An APB transfer in flight when reset asserts is aborted; nothing is committed.
- APB FSM states:
  - IDLE: moves to SETUP on psel & ~penable.
  - SETUP: moves to ACCESS on the next cycle.
  - ACCESS: wait counter counts WAIT_CYCLES cycles with pready=0, then moves to DONE.
  - DONE: pready=1 for exactly one cycle, then returns to IDLE. Back-to-back SETUP is allowed from DONE.
  - With WAIT_CYCLES=0, pready=1 in the first ACCESS cycle.
- Commit timing: a write commits on the DONE cycle and the register holds the new value from the next edge. Read data is sampled onto prdata in the DONE cycle. prdata=0x00 whenever pready=0.
- Register map:
  - 0x00 TDR: read/write, reload value.
  - 0x01 TCR: read/write. bit7 LOAD, bit5 DOWN, bit4 EN, bits1:0 CKS. Unused bits read 0.
  - 0x02 TSR: bit1 UDF, bit0 OVF. Write-1-to-clear; writing 0 has no effect.
  - 0x03 TCNT: read-only. A write is ignored with pslverr=0.
  - Any other address: pslverr=1 with pready, write ignored, prdata=0x00.
- Prescaler:
  - Free-running counter that advances only while EN=1.
  - Issues a one-cycle tick every 2^(CKS+1) pclk cycles.
  - Cleared to 0 when EN=0 and whenever a TCR write commits.
  - The first tick comes 2^(CKS+1) cycles after the enabling write commits.
- LOAD:
  - A committed TCR write with bit7=1 copies TDR into TCNT on the next edge.
  - LOAD beats a simultaneous tick.
  - LOAD stays set as written and is re-applied only by a new TCR write.
- Counting:
  - On a tick with DOWN=0, TCNT increments; the step 0xFF->0x00 sets OVF.
  - On a tick with DOWN=1, TCNT decrements; the step 0x00->0xFF sets UDF.
  - A flag set and a W1C clear in the same cycle leave the flag set.
- Stopping: EN=0 freezes TCNT at its current value.

Optional Feature:
TIMER_INT_EN
- Defined: adds output port irq (1 bit) and TCR bits 3 (OVIE) and 2 (UDIE). irq = (OVF&OVIE)|(UDF&UDIE), registered, so it follows the flag by one cycle. irq=0 on reset.
- Undefined: no irq port; TCR bits 3:2 read 0 and writes to them are ignored.

Decomposition:
- Package timer_pkg holds:
  - address constants ADDR_TDR=0x00, ADDR_TCR=0x01, ADDR_TSR=0x02, ADDR_TCNT=0x03;
  - TCR bit indices and TSR bit indices;
  - APB FSM state encoding IDLE, SETUP, ACCESS, DONE.
- Sub-module timer_prescaler, with inputs pclk, presetn, en, cks[1:0], clr and output tick.

Test Plan:
- Write TCR=0x10, exactly 200 pclk after commit write TCR=0x00, read TCNT -> 0x64; TCR reads 0x00.
- Count to 0x64 as above, hold presetn=0 for 200 pclk, release, wait 503 pclk -> TDR/TCR/TSR/TCNT read 0x00, pready=0 during reset, TCNT stays 0x00.
- TDR=0xFE, TCR=0x90 -> TCNT 0xFE, 0xFF, then 0x00 after 4 pclk; TSR reads 0x01; write TSR=0x01 -> TSR reads 0x00.
- TDR=0x01, TCR=0xB3 -> 0x00 after 16 pclk, 0xFF after 32 pclk, TSR reads 0x02; write TSR=0x01 -> TSR still 0x02.
- WAIT_CYCLES=3: read TCR -> pready rises 3 cycles after penable, held 1 cycle. Write paddr=0x07 -> pslverr=1, prdata=0x00, no register changes.
- TIMER_INT_EN with TCR=0x98 (LOAD+EN+OVIE), TDR=0xFF -> irq=1 one cycle after OVF sets; clearing OVF drops irq next cycle.

Source files
------------

// File: rtl/timer_pkg.sv
// timer_pkg: shared constants for apb_timer_slave.
// Holds register addresses, TCR/TSR bit positions and the APB FSM state encoding.
package timer_pkg;

    localparam logic [7:0] ADDR_TDR  = 8'h00;
    localparam logic [7:0] ADDR_TCR  = 8'h01;
    localparam logic [7:0] ADDR_TSR  = 8'h02;
    localparam logic [7:0] ADDR_TCNT = 8'h03;

    localparam int TCR_LOAD = 7;
    localparam int TCR_DOWN = 5;
    localparam int TCR_EN   = 4;
    localparam int TCR_OVIE = 3;
    localparam int TCR_UDIE = 2;

    localparam int TSR_UDF = 1;
    localparam int TSR_OVF = 0;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} apb_state_t;

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: divides pclk by 2^(cks+1) and emits a one-cycle tick.
// Ports: pclk, presetn (async active-low), en (run), cks (divider select),
//        clr (restart the count), tick (one pclk wide pulse).
module timer_prescaler (
    input  logic       pclk,
    input  logic       presetn,
    input  logic       en,
    input  logic [1:0] cks,
    input  logic       clr,
    output logic       tick
);

    logic [3:0] cnt;
    logic [3:0] mask;

    // The low cks+1 bits of a free-running count are all ones once per period.
    assign mask = 4'((5'd2 << cks) - 5'd1);
    assign tick = en && ((cnt & mask) == mask);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) cnt <= '0;
        else          cnt <= (clr || !en) ? 4'd0 : cnt + 4'd1;
    end

endmodule

// File: rtl/apb_timer_slave.sv
// apb_timer_slave: APB completer with four byte registers and an 8-bit up/down timer.
// Ports: pclk, presetn (async active-low), APB psel/penable/pwrite/paddr/pwdata,
//        prdata/pready/pslverr responses, irq when TIMER_INT_EN is defined.
// Option: define TIMER_INT_EN to add the irq output and the OVIE/UDIE bits of TCR.
module apb_timer_slave
    import timer_pkg::*;
#(
    parameter int WAIT_CYCLES = 0,
    parameter int ADDR_W      = 8
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [7:0]        pwdata,
    output logic [7:0]        prdata,
    output logic              pready,
    output logic              pslverr
`ifdef TIMER_INT_EN
    ,
    output logic              irq
`endif
);

`ifdef TIMER_INT_EN
    localparam logic [7:0] TCR_MASK = 8'hBF;
`else
    localparam logic [7:0] TCR_MASK = 8'hB3;
`endif

    apb_state_t state, phase;
    logic [3:0] wcnt;
    logic [7:0] tdr, tcr, tcnt, rdata;
    logic [1:0] tsr, tsr_set, tsr_clr;
    logic       hit, finish, wr, wr_tcr, load, tick;

    // The setup phase is recognised in the cycle it appears on the bus, so
    // with no wait states pready can rise in the very first access cycle.
    assign phase  = (state == IDLE && psel && !penable) ? SETUP : state;
    assign finish = (phase == SETUP && WAIT_CYCLES == 0) || (phase == ACCESS && wcnt == 4'd0);
    assign hit    = paddr <= ADDR_W'(ADDR_TCNT);

    assign rdata = (paddr == ADDR_W'(ADDR_TDR))  ? tdr :
                   (paddr == ADDR_W'(ADDR_TCR))  ? tcr :
                   (paddr == ADDR_W'(ADDR_TSR))  ? {6'd0, tsr} :
                   (paddr == ADDR_W'(ADDR_TCNT)) ? tcnt : 8'h00;

    assign wr      = state == DONE && pwrite;
    assign wr_tcr  = wr && paddr == ADDR_W'(ADDR_TCR);
    assign load    = wr_tcr && pwdata[TCR_LOAD];
    assign tsr_clr = (wr && paddr == ADDR_W'(ADDR_TSR)) ? pwdata[1:0] : 2'b00;

    // A LOAD replaces any tick in the same cycle, so it cannot raise a flag either.
    assign tsr_set[TSR_OVF] = tick && !load && !tcr[TCR_DOWN] && tcnt == 8'hFF;
    assign tsr_set[TSR_UDF] = tick && !load &&  tcr[TCR_DOWN] && tcnt == 8'h00;

    timer_prescaler u_prescaler (
        .pclk    (pclk),
        .presetn (presetn),
        .en      (tcr[TCR_EN]),
        .cks     (tcr[1:0]),
        .clr     (wr_tcr),
        .tick    (tick)
    );

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state   <= IDLE;
            wcnt    <= '0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
        end else begin
            state   <= finish ? DONE : phase == SETUP ? ACCESS : phase == DONE ? IDLE : phase;
            wcnt    <= phase == SETUP ? 4'(WAIT_CYCLES - 1) : wcnt - 4'(phase == ACCESS);
            pready  <= finish;
            pslverr <= finish && !hit;
            prdata  <= (finish && !pwrite) ? rdata : 8'h00;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            tdr  <= '0;
            tcr  <= '0;
            tsr  <= '0;
            tcnt <= '0;
        end else begin
            if (wr && paddr == ADDR_W'(ADDR_TDR)) tdr <= pwdata;
            if (wr_tcr) tcr <= pwdata & TCR_MASK;
            // Setting wins over a same-cycle write-1-to-clear.
            tsr  <= (tsr & ~tsr_clr) | tsr_set;
            tcnt <= load ? tdr : !tick ? tcnt : tcr[TCR_DOWN] ? tcnt - 8'd1 : tcnt + 8'd1;
        end
    end

`ifdef TIMER_INT_EN
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) irq <= 1'b0;
        else          irq <= |(tsr & {tcr[TCR_UDIE], tcr[TCR_OVIE]});
    end
`endif

endmodule

// File: tb/tb_apb_timer_slave.sv
// tb_apb_timer_slave: self-checking bench for apb_timer_slave (zero and three wait states).
module tb_apb_timer_slave;
    import timer_pkg::*;

`ifdef TIMER_INT_EN
    localparam logic [7:0] TCR_RD = 8'h2E;
`else
    localparam logic [7:0] TCR_RD = 8'h22;
`endif

    logic       clk, presetn, psel, penable, pwrite, use_w;
    logic [7:0] paddr, pwdata;
    logic       psel_a, psel_w, pready_a, pready_w, pslverr_a, pslverr_w;
    logic [7:0] prdata_a, prdata_w;
    logic       pready, pslverr;
    logic [7:0] prdata;
`ifdef TIMER_INT_EN
    logic       irq, irq_w;
`endif

    int         errors, checks, cyc;
    logic [7:0] b_rd;
    logic       b_er, b_held;
    int         b_waits;
    logic [7:0] m_cnt;
    logic [1:0] m_sr;

    typedef struct {
        logic       w;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] rd;
        logic       err;
    } vec_t;
    vec_t tbl[13];

    assign psel_a  = psel & ~use_w;
    assign psel_w  = psel & use_w;
    assign pready  = use_w ? pready_w : pready_a;
    assign pslverr = use_w ? pslverr_w : pslverr_a;
    assign prdata  = use_w ? prdata_w : prdata_a;

    apb_timer_slave #(.WAIT_CYCLES(0), .ADDR_W(8)) dut (
        .pclk(clk), .presetn(presetn), .psel(psel_a), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata_a), .pready(pready_a), .pslverr(pslverr_a)
`ifdef TIMER_INT_EN
        , .irq(irq)
`endif
    );

    apb_timer_slave #(.WAIT_CYCLES(3), .ADDR_W(8)) dut_w (
        .pclk(clk), .presetn(presetn), .psel(psel_w), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata_w), .pready(pready_w), .pslverr(pslverr_w)
`ifdef TIMER_INT_EN
        , .irq(irq_w)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected to have finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One complete APB transfer; commit edge of a write is the last edge before return.
    task automatic bus(input logic w, input logic [7:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        b_waits = 0;
        while (!pready && b_waits < 40) begin
            @(posedge clk); #1;
            b_waits++;
        end
        if (!pready) begin
            checks++;
            errors++;
            $display("FAIL pready timeout: got 0 after %0d cycles, expected 1", b_waits);
        end
        b_rd = prdata;
        b_er = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        b_held = pready;
    endtask

    // Runs the timer for exactly d cycles between two TCR commits and checks TCNT/TSR
    // against the tick arithmetic: ticks = d / 2^(cks+1).
    task automatic run_count(input logic [7:0] t_dr, input logic [7:0] t_cr, input int d,
                             output logic [7:0] cnt, output logic [7:0] sr);
        int t0, t1, ticks, start, v;
        bus(1'b1, ADDR_TDR, t_dr);
        bus(1'b1, ADDR_TCR, t_cr);
        t0 = cyc;
        while (cyc + 3 < t0 + d) begin
            @(posedge clk); #1;
        end
        bus(1'b1, ADDR_TCR, 8'h00);
        t1 = cyc;
        ticks = (t1 - t0) >> (int'(t_cr[1:0]) + 1);
        start = t_cr[7] ? int'(t_dr) : int'(m_cnt);
        v = t_cr[5] ? start - ticks : start + ticks;
        m_sr = m_sr | {t_cr[5] && v < 0, !t_cr[5] && v > 255};
        m_cnt = 8'(v);
        bus(1'b0, ADDR_TCNT, 8'h00);
        cnt = b_rd;
        chk($sformatf("tcnt tcr=%0h d=%0d", t_cr, d), b_rd, m_cnt);
        bus(1'b0, ADDR_TSR, 8'h00);
        sr = b_rd;
        chk($sformatf("tsr tcr=%0h d=%0d", t_cr, d), b_rd, {6'd0, m_sr});
    endtask

    initial begin
        logic [7:0] c, s, rdr, rcr;
        int t0, bad;
        errors = 0; checks = 0; cyc = 0; use_w = 1'b0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        m_cnt = 8'h00; m_sr = 2'b00;

        tbl[0]  = '{1'b1, ADDR_TDR,  8'hA5, 8'h00, 1'b0};
        tbl[1]  = '{1'b0, ADDR_TDR,  8'h00, 8'hA5, 1'b0};
        tbl[2]  = '{1'b1, ADDR_TCR,  8'h6E, 8'h00, 1'b0};
        tbl[3]  = '{1'b0, ADDR_TCR,  8'h00, TCR_RD, 1'b0};
        tbl[4]  = '{1'b1, ADDR_TCNT, 8'h55, 8'h00, 1'b0};
        tbl[5]  = '{1'b0, ADDR_TCNT, 8'h00, 8'h00, 1'b0};
        tbl[6]  = '{1'b1, 8'h07,     8'h12, 8'h00, 1'b1};
        tbl[7]  = '{1'b0, 8'h07,     8'h00, 8'h00, 1'b1};
        tbl[8]  = '{1'b0, ADDR_TDR,  8'h00, 8'hA5, 1'b0};
        tbl[9]  = '{1'b0, ADDR_TCR,  8'h00, TCR_RD, 1'b0};
        tbl[10] = '{1'b1, ADDR_TCR,  8'h00, 8'h00, 1'b0};
        tbl[11] = '{1'b0, ADDR_TSR,  8'h00, 8'h00, 1'b0};
        tbl[12] = '{1'b0, 8'hFF,     8'h00, 8'h00, 1'b1};

        presetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset pready", pready_a, 0);
        chk("reset prdata", prdata_a, 0);
        chk("reset pslverr", pslverr_a, 0);
        presetn = 1'b1;

        for (int i = 0; i < 13; i++) begin
            bus(tbl[i].w, tbl[i].a, tbl[i].d);
            if (i == 0) chk("zero-wait pready", b_waits, 0);
            chk($sformatf("tbl%0d pslverr", i), b_er, tbl[i].err);
            if (!tbl[i].w) chk($sformatf("tbl%0d prdata", i), b_rd, tbl[i].rd);
        end

        run_count(8'h00, 8'h10, 200, c, s);
        chk("count 200 tcnt", c, 8'h64);
        bus(1'b0, ADDR_TCR, 8'h00);
        chk("count 200 tcr", b_rd, 8'h00);

        @(posedge clk); #1;
        presetn = 1'b0;
        bad = 0;
        repeat (200) begin
            @(posedge clk); #1;
            if (pready_a || pready_w) bad++;
        end
        chk("pready during reset", bad, 0);
        presetn = 1'b1;
        m_cnt = 8'h00; m_sr = 2'b00;
        repeat (503) @(posedge clk);
        #1;
        bus(1'b0, ADDR_TDR, 8'h00);  chk("post-reset tdr", b_rd, 0);
        bus(1'b0, ADDR_TCR, 8'h00);  chk("post-reset tcr", b_rd, 0);
        bus(1'b0, ADDR_TSR, 8'h00);  chk("post-reset tsr", b_rd, 0);
        bus(1'b0, ADDR_TCNT, 8'h00); chk("post-reset tcnt", b_rd, 0);

        run_count(8'hFE, 8'h90, 4, c, s);
        chk("overflow tcnt", c, 8'h00);
        chk("overflow tsr", s, 8'h01);
        bus(1'b1, ADDR_TSR, 8'h01);
        m_sr = 2'b00;
        bus(1'b0, ADDR_TSR, 8'h00);
        chk("ovf w1c", b_rd, 8'h00);

        run_count(8'h01, 8'hB3, 32, c, s);
        chk("underflow tcnt", c, 8'hFF);
        chk("underflow tsr", s, 8'h02);
        bus(1'b1, ADDR_TSR, 8'h01);
        bus(1'b0, ADDR_TSR, 8'h00);
        chk("udf kept by w1c of ovf", b_rd, 8'h02);
        bus(1'b1, ADDR_TSR, 8'h02);
        m_sr = 2'b00;
        bus(1'b0, ADDR_TSR, 8'h00);
        chk("udf w1c", b_rd, 8'h00);

        use_w = 1'b1;
        bus(1'b0, ADDR_TCR, 8'h00);
        chk("wait3 waits", b_waits, 3);
        chk("wait3 pready one cycle", b_held, 0);
        chk("wait3 tcr", b_rd, 8'h00);
        bus(1'b1, ADDR_TDR, 8'h3C);
        bus(1'b1, 8'h07, 8'hFF);
        chk("wait3 bad addr pslverr", b_er, 1);
        chk("wait3 bad addr prdata", b_rd, 8'h00);
        bus(1'b0, ADDR_TDR, 8'h00);
        chk("wait3 tdr kept", b_rd, 8'h3C);
        bus(1'b0, ADDR_TCR, 8'h00);
        chk("wait3 tcr kept", b_rd, 8'h00);
        use_w = 1'b0;

`ifdef TIMER_INT_EN
        bus(1'b1, ADDR_TDR, 8'hFF);
        bus(1'b1, ADDR_TCR, 8'h98);
        t0 = cyc;
        chk("irq before ovf", irq, 0);
        while (cyc < t0 + 2) begin
            @(posedge clk); #1;
        end
        chk("irq same cycle as ovf", irq, 0);
        @(posedge clk); #1;
        chk("irq after ovf", irq, 1);
        bus(1'b1, ADDR_TSR, 8'h01);
        chk("irq lags clear", irq, 1);
        @(posedge clk); #1;
        chk("irq after clear", irq, 0);
        bus(1'b1, ADDR_TCR, 8'h00);
        m_cnt = 8'(255 + ((cyc - t0) >> 1));
        m_sr = 2'b00;
`endif

        for (int i = 0; i < 24; i++) begin
            rdr = 8'($urandom);
            rcr = {1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), 1'b1, 2'b00,
                   2'($urandom_range(0, 3))};
            run_count(rdr, rcr, int'($urandom_range(3, 300)), c, s);
            bus(1'b1, ADDR_TSR, 8'h03);
            m_sr = 2'b00;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
